// File: rtl/spdif_tx_param.sv
// spdif_tx_param: S/PDIF consumer transmitter with one-pair holding buffer, channel-status block and BMC line coding
module spdif_tx_param #(
  parameter int CLK_DIV  = 2,
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_validity,
  input  logic [3:0]          cs_rate,
  input  logic                cs_copy_ok,
  output logic                spdif_out,
  output logic                block_start,
  output logic [7:0]          frame_idx,
  output logic                underrun
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0] WL = SAMPLE_W == 24 ? 4'b1011 : SAMPLE_W == 20 ? 4'b1010 : 4'b0010;
  logic [CW-1:0] ui_cnt;
  logic [5:0] ui_pos;
  logic sub, lvl, pre_pol, first;
  logic h_full, h_v, f_v, cs_copy;
  logic [SAMPLE_W-1:0] h_left, h_right, f_left, f_right;
  logic [3:0] cs_r;
  logic tick, load, c_bit, bit_v, pol, nlvl;
  logic [7:0] nxt_idx, idx_eff, pat;
  logic [23:0] s24;
  logic [31:0] word;
  assign s_ready = !h_full;
  always_comb begin
    tick    = enable && ui_cnt == CW'(0);
    load    = tick && !sub && ui_pos == 6'd0;
    nxt_idx = first ? 8'd0 : frame_idx == 8'd191 ? 8'd0 : frame_idx + 8'd1;
    idx_eff = load ? nxt_idx : frame_idx;
    c_bit   = (frame_idx == 8'd2 && cs_copy) || (frame_idx[7:2] == 6'd6 && cs_r[frame_idx[1:0]])
              || (frame_idx[7:2] == 6'd8 && WL[frame_idx[1:0]]);
    // samples are left-justified so the MSB always lands in slot 27
    s24     = 24'(sub ? f_right : f_left) << (24 - SAMPLE_W);
    word    = {^{c_bit, f_v, s24}, c_bit, 1'b0, f_v, s24, 4'b0};
    bit_v   = word[ui_pos[5:1]];
    pat     = sub ? 8'b11100100 : idx_eff == 8'd0 ? 8'b11101000 : 8'b11100010;
    pol     = ui_pos == 6'd0 ? lvl : pre_pol;
    nlvl    = ui_pos < 6'd8 ? pat[3'd7 - ui_pos[2:0]] ^ pol : ui_pos[0] ? lvl ^ bit_v : !lvl;
  end
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      ui_cnt      <= '0;
      ui_pos      <= '0;
      sub         <= 1'b0;
      lvl         <= 1'b0;
      pre_pol     <= 1'b0;
      first       <= 1'b1;
      frame_idx   <= '0;
      block_start <= 1'b0;
      underrun    <= 1'b0;
      spdif_out   <= 1'b0;
      f_left      <= '0;
      f_right     <= '0;
      f_v         <= 1'b0;
      cs_copy     <= 1'b0;
      cs_r        <= '0;
    end else begin
      ui_cnt      <= ui_cnt == CW'(CLK_DIV - 1) ? CW'(0) : ui_cnt + CW'(1);
      spdif_out   <= lvl;
      block_start <= 1'b0;
      underrun    <= 1'b0;
      if (tick) begin
        lvl    <= nlvl;
        ui_pos <= ui_pos + 6'd1;
        if (ui_pos == 6'd63) sub <= !sub;
        if (ui_pos == 6'd0) pre_pol <= lvl;
      end
      if (load) begin
        first       <= 1'b0;
        frame_idx   <= nxt_idx;
        block_start <= nxt_idx == 8'd0;
        underrun    <= !h_full;
        f_left      <= h_full ? h_left : '0;
        f_right     <= h_full ? h_right : '0;
        f_v         <= h_full ? h_v : 1'b1;
        if (nxt_idx == 8'd0) begin
          cs_copy <= cs_copy_ok;
          cs_r    <= cs_rate;
        end
      end
    end
  end
  // the holding buffer survives enable=0; only rst empties it
  always_ff @(posedge clk) begin
    if (rst) h_full <= 1'b0;
    else if (s_valid && !h_full) begin
      h_full  <= 1'b1;
      h_left  <= s_left;
      h_right <= s_right;
      h_v     <= s_validity;
    end else if (load) h_full <= 1'b0;
  end
endmodule

// File: tb/tb_spdif_tx_param.sv
// tb_spdif_tx_param: directed checks of BMC line, preambles, handshake, underrun and channel status
module tb_spdif_tx_param;
  localparam logic [7:0] PB = 8'b11101000, PM = 8'b11100010, PW = 8'b11100100;
  localparam logic [191:0] CEXP = 192'h0A_0300_0004;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic ea = 0, eb = 0, ec = 0, va = 0, vb = 0, vc = 0, s_validity = 0, cs_copy_ok = 0;
  logic [23:0] s_left = 0, s_right = 0;
  logic [3:0] cs_rate = 0;
  logic a_rdy, a_out, a_bs, a_ur, b_rdy, b_out, b_bs, b_ur, c_rdy, c_out, c_bs, c_ur;
  logic [7:0] a_idx, b_idx, c_idx;
  int sel = 0, div = 2;
  logic line, bst, rdy, ur, vld;
  logic [7:0] idx;
  int n_cmp = 0, n_bad = 0, cyc = 0, glitch = 0, bmc_err = 0, bad = 0, ur0 = 0;
  int ur_cnt = 0, ur_last = 0, ur_gap = 0, bs_last = 0, bs_gap = 0, acc = 0, acc_last = 0, acc_gap = 0;
  logic lv = 0, feed = 0, b;
  logic [23:0] seq = 0;
  logic [31:0] w;
  logic [191:0] got = 0;
  logic [35:0] got2 = 0;

  spdif_tx_param #(.CLK_DIV(2), .SAMPLE_W(24)) u_a (
    .clk(clk), .rst(rst), .enable(ea), .s_valid(va), .s_ready(a_rdy), .s_left(s_left), .s_right(s_right),
    .s_validity(s_validity), .cs_rate(cs_rate), .cs_copy_ok(cs_copy_ok), .spdif_out(a_out),
    .block_start(a_bs), .frame_idx(a_idx), .underrun(a_ur));
  spdif_tx_param #(.CLK_DIV(3), .SAMPLE_W(16)) u_b (
    .clk(clk), .rst(rst), .enable(eb), .s_valid(vb), .s_ready(b_rdy), .s_left(s_left[15:0]),
    .s_right(s_right[15:0]), .s_validity(s_validity), .cs_rate(cs_rate), .cs_copy_ok(cs_copy_ok),
    .spdif_out(b_out), .block_start(b_bs), .frame_idx(b_idx), .underrun(b_ur));
  spdif_tx_param #(.CLK_DIV(1), .SAMPLE_W(20)) u_c (
    .clk(clk), .rst(rst), .enable(ec), .s_valid(vc), .s_ready(c_rdy), .s_left(s_left[19:0]),
    .s_right(s_right[19:0]), .s_validity(s_validity), .cs_rate(cs_rate), .cs_copy_ok(cs_copy_ok),
    .spdif_out(c_out), .block_start(c_bs), .frame_idx(c_idx), .underrun(c_ur));

  always_comb begin
    line = sel == 0 ? a_out : sel == 1 ? b_out : c_out;
    bst  = sel == 0 ? a_bs : sel == 1 ? b_bs : c_bs;
    rdy  = sel == 0 ? a_rdy : sel == 1 ? b_rdy : c_rdy;
    ur   = sel == 0 ? a_ur : sel == 1 ? b_ur : c_ur;
    vld  = sel == 0 ? va : sel == 1 ? vb : vc;
    idx  = sel == 0 ? a_idx : sel == 1 ? b_idx : c_idx;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (vld && rdy) acc <= acc + 1;
    if (ur) begin
      ur_cnt  <= ur_cnt + 1;
      ur_gap  <= cyc - ur_last;
      ur_last <= cyc;
    end
    if (bst) begin
      bs_gap   <= cyc - bs_last;
      bs_last  <= cyc;
      acc_gap  <= acc - acc_last;
      acc_last <= acc;
    end
  end

  // incrementing-sample source: advances only after the previous pair was accepted
  initial begin
    logic x;
    forever begin
      @(negedge clk);
      x = feed && va && a_rdy;
      @(posedge clk);
      #1;
      if (feed && x) begin
        seq = seq + 1;
        s_left = seq;
        s_right = ~seq;
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [23:0] s, input logic v, input logic c);
    return {^{c, v, s}, c, 1'b0, v, s, 4'b0};
  endfunction

  task automatic wait_bs(input string tag, input int limit);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bst && n < limit);
    chk({tag, "_block_start"}, bst, 1);
    lv = line;
  endtask

  task automatic rd_ui(output logic v);
    logic f = 0;
    for (int i = 0; i < div; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) f = line;
      else if (line !== f) glitch++;
    end
    v = f;
  endtask

  task automatic rd_sub(input string tag, input logic [7:0] pat, output logic [31:0] wd);
    logic [63:0] u;
    logic [7:0] pre;
    logic v;
    for (int k = 0; k < 64; k++) begin
      rd_ui(v);
      u[k] = v;
    end
    for (int k = 0; k < 8; k++) pre[7-k] = u[k];
    chk({tag, "_preamble"}, pre, pat ^ {8{lv}});
    wd = 0;
    for (int s = 4; s < 32; s++) begin
      if (u[2*s] === u[2*s-1]) bmc_err++;
      wd[s] = u[2*s] ^ u[2*s+1];
    end
    lv = u[63];
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_line", a_out, 0);
    chk("rst_ready", a_rdy, 1);
    chk("rst_block_start", a_bs, 0);
    chk("rst_underrun", a_ur, 0);
    chk("rst_frame_idx", a_idx, 0);
    // first pair, then starvation
    s_left = 24'h000001;
    s_right = 24'h800000;
    va = 1;
    @(posedge clk);
    #1 va = 0;
    chk("t1_ready_full", a_rdy, 0);
    @(posedge clk);
    #1 chk("t1_idle_line", a_out, 0);
    ea = 1;
    wait_bs("t1", 10);
    chk("t1_frame_idx", idx, 0);
    chk("t1_ready_after_load", rdy, 1);
    rd_sub("t1_left", PB, w);
    chk("t1_left_word", w, exp_word(24'h000001, 0, 0));
    rd_sub("t1_right", PW, w);
    chk("t1_right_word", w, exp_word(24'h800000, 0, 0));
    for (int f = 1; f < 3; f++) begin
      rd_sub("t2_left", PM, w);
      chk("t2_left_word", w, exp_word(0, 1, 0));
      rd_sub("t2_right", PW, w);
      chk("t2_right_word", w, exp_word(0, 1, 0));
    end
    chk("t2_underrun_count", ur_cnt, 2);
    chk("t2_underrun_gap", ur_gap, 256);
    ea = 0;
    // continuous stream across a full block
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    ur0 = ur_cnt;
    seq = 1;
    s_left = seq;
    s_right = ~seq;
    va = 1;
    feed = 1;
    repeat (3) @(posedge clk);
    #1 ea = 1;
    wait_bs("t3_first", 10);
    wait_bs("t3_second", 50000);
    chk("t3_frame_idx", idx, 0);
    rd_sub("t3_left", PB, w);
    chk("t3_left_word", w, exp_word(24'd193, 0, 0));
    rd_sub("t3_right", PW, w);
    chk("t3_right_word", w, exp_word(~24'd193, 0, 0));
    chk("t3_block_gap", bs_gap, 49152);
    chk("t3_accepts_per_block", acc_gap, 192);
    chk("t3_no_underrun", ur_cnt - ur0, 0);
    feed = 0;
    @(posedge clk);
    #2 va = 0;
    ea = 0;
    // channel status decode at 20-bit width, CLK_DIV=1
    sel = 2;
    div = 1;
    cs_rate = 4'b0011;
    cs_copy_ok = 1;
    ec = 1;
    wait_bs("t4", 10);
    for (int f = 0; f < 192; f++) begin
      if (f == 100) cs_rate = 4'b0101;
      rd_sub("t4_left", f == 0 ? PB : PM, w);
      got[f] = w[30];
      if (w !== exp_word(0, 1, CEXP[f])) bad++;
      rd_sub("t4_right", PW, w);
      if (w !== exp_word(0, 1, CEXP[f])) bad++;
    end
    chk("t4_cs_low", got[63:0], CEXP[63:0]);
    chk("t4_cs_high_zero", |got[191:64], 0);
    chk("t4_word_errors", bad, 0);
    for (int f = 0; f < 36; f++) begin
      rd_sub("t4n_left", f == 0 ? PB : PM, w);
      got2[f] = w[30];
      rd_sub("t4n_right", PW, w);
    end
    chk("t4_next_rate", got2[27:24], 4'b0101);
    chk("t4_next_wordlen", got2[35:32], 4'b1010);
    ec = 0;
    // 16-bit samples at CLK_DIV=3
    sel = 1;
    div = 3;
    s_left = 24'h00FFFF;
    s_right = 24'h00FFFF;
    vb = 1;
    @(posedge clk);
    #1 vb = 0;
    eb = 1;
    wait_bs("t5", 10);
    rd_sub("t5_left", PB, w);
    chk("t5_left_word", w, exp_word(24'hFFFF00, 0, 0));
    rd_sub("t5_right", PW, w);
    chk("t5_right_word", w, exp_word(24'hFFFF00, 0, 0));
    rd_sub("t5_f1_left", PM, w);
    chk("t5_f1_left_word", w, exp_word(0, 1, 0));
    // reset in the middle of slot 15 of a right subframe
    vb = 1;
    rd_ui(b);
    vb = 0;
    repeat (29) rd_ui(b);
    chk("t6_ready_before", rdy, 0);
    rst = 1;
    @(posedge clk);
    #1 chk("t6_line_low", line, 0);
    chk("t6_ready_after", rdy, 1);
    rst = 0;
    wait_bs("t6", 10);
    chk("t6_frame_idx", idx, 0);
    rd_sub("t6_left", PB, w);
    chk("t6_left_word", w, exp_word(0, 1, 0));
    chk("bmc_first_ui_toggle", bmc_err, 0);
    chk("ui_stable", glitch, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
